cpu_if_prefetch: RTL
====================

Name: cpu_if_prefetch

Overview:
- Parametrised successor to the single-request instruction fetch stage.
- Issues sequential instruction reads on a pipelined Wishbone master port, with up to Depth requests in flight.
- Buffers returned words in a Depth-entry FIFO and presents them to decode through a valid/ready handshake.
- Supports redirect (branch/trap) with flush of in-flight responses, and reports bus errors per instruction.

Parameters:
- AddrWidth, 32, address width of bus_addr / PCs.
- DataWidth, 32, instruction/bus data width; multiple of 8.
- Depth, 4, FIFO entries and max outstanding credits; power of 2, >= 2.
- ResetPc, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  in  AddrWidth  new fetch address; low log2(DataWidth/8) bits are ignored (forced 0).
- instr_ready  in  1  decode accepts the head entry.
- instr_valid  out  1  head entry valid.
- instr  out  DataWidth  head instruction word.
- instr_pc  out  AddrWidth  address of the head word.
- instr_err  out  1  head word returned with bus_err; instr is don't-care.
- bus_data_s  in  DataWidth  read data.
- bus_ack  in  1  response, success.
- bus_err  in  1  response, error (never together with ack).
- bus_stall  in  1  slave cannot accept this cycle.
- bus_data_m  out  DataWidth  tied 0.
- bus_addr  out  AddrWidth  request address.
- bus_sel  out  DataWidth/8  tied all ones.
- bus_cyc  out  1  cycle active.
- bus_stb  out  1  request strobe.
- bus_we  out  1  tied 0.

Behaviour:
- Reset: state=FETCH; fetch_pc=resp_pc=ResetPc; outstanding=0; FIFO empty. Outputs: instr_valid=0, bus_stb=0, bus_cyc=0, bus_addr=ResetPc.
- Credits: issue is allowed only when outstanding + fifo_count < Depth.
  - outstanding width is clog2(Depth+1); it never exceeds Depth.
- FETCH state:
  - bus_stb=1 whenever credit is available; bus_addr=fetch_pc.
  - Accept = stb && !stall; on accept, fetch_pc += DataWidth/8 and outstanding++.
  - While stalled, stb and addr are held stable.
  - Address wraps modulo 2^AddrWidth.
- Response (ack|err):
  - outstanding--.
  - In FETCH, push {bus_data_s, resp_pc, bus_err}, then resp_pc += DataWidth/8.
  - Accept and response in the same cycle leave outstanding unchanged.
- bus_err in FETCH: the err entry is pushed, then state moves to HALT.
- HALT state: bus_stb=0; remaining responses are discarded; the FIFO drains normally; no further fetch until redirect.
- Redirect (any state):
  - FIFO flushed; fetch_pc=resp_pc=redirect_pc aligned.
  - Next state is FETCH if outstanding (after this cycle's response) is 0, else DRAIN.
  - bus_stb is 0 in the redirect cycle. A request stalled in that cycle is withdrawn and not counted.
- DRAIN state:
  - bus_stb=0; responses are discarded and decrement outstanding.
  - Go to FETCH when outstanding reaches 0; stb may rise the following cycle.
  - A new redirect in DRAIN overwrites the target.
- bus_cyc = bus_stb || outstanding != 0. It deasserts only with no requests in flight.
- Output handshake:
  - instr_valid = fifo not empty; pop on instr_valid && instr_ready.
  - Head fields are stable while valid && !ready.
  - Redirect beats pop in the same cycle: flush wins.
  - Push and pop in the same cycle on a full FIFO are legal.
  - Pushes never overflow, by the credit rule.
- Latency: ack at cycle N gives instr_valid at N+1. With zero-wait slave and instr_ready=1, sustained throughput is 1 word/cycle.
- Reset mid-operation clears all state immediately. The bus owner must tolerate abandoned responses.

Test Plan:
- Reset, zero-wait slave returning data=addr, instr_ready=1 -> bus_addr 0,4,8,... one per cycle; instr/instr_pc pairs (0,0),(4,4),(8,8) in order with no gaps after the first.
- instr_ready=0, Depth=4 -> exactly 4 accepts, then bus_stb=0 and bus_cyc=0. Raising ready then yields PCs 0..12 and fetching resumes at 16.
- bus_stall=1 for 3 cycles at addr 8 -> addr 8 held with stb=1; one accept only; instr_pc sequence has no duplicates or gaps.
- 3 requests outstanding, redirect_pc=0x103 -> FIFO empty next cycle; 3 responses discarded; first new request at 0x100; first instr_pc=0x100.
- bus_err on response for 0x8 -> entries 0x0, 0x4 with err=0, then 0x8 with err=1. No stb until redirect to 0x40, after which fetch restarts at 0x40.
- Redirect in same cycle as pop and ack -> popped entry not consumed, ack data discarded, outstanding decremented correctly (reaches 0, bus_cyc drops).

Source files
------------

// File: rtl/cpu_if_prefetch_if.sv
// Pipelined Wishbone read-bus bundle between the instruction prefetcher (master)
// and the instruction memory / interconnect (slave).
interface cpu_if_prefetch_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) ();

  logic [DataWidth-1:0]   bus_data_s;
  logic                   bus_ack;
  logic                   bus_err;
  logic                   bus_stall;
  logic [DataWidth-1:0]   bus_data_m;
  logic [AddrWidth-1:0]   bus_addr;
  logic [DataWidth/8-1:0] bus_sel;
  logic                   bus_cyc;
  logic                   bus_stb;
  logic                   bus_we;

  modport master (
    input  bus_data_s, bus_ack, bus_err, bus_stall,
    output bus_data_m, bus_addr, bus_sel, bus_cyc, bus_stb, bus_we
  );

  modport slave (
    output bus_data_s, bus_ack, bus_err, bus_stall,
    input  bus_data_m, bus_addr, bus_sel, bus_cyc, bus_stb, bus_we
  );

endinterface

// File: rtl/cpu_if_prefetch.sv
// Credit-based instruction prefetcher: issues sequential pipelined Wishbone reads
// and queues returned words (with PC and error flag) for decode.
module cpu_if_prefetch #(
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          Depth     = 4,
  parameter logic [AddrWidth-1:0] ResetPc   = {AddrWidth{1'b0}}
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 redirect_valid,
  input  logic [AddrWidth-1:0] redirect_pc,
  input  logic                 instr_ready,
  output logic                 instr_valid,
  output logic [DataWidth-1:0] instr,
  output logic [AddrWidth-1:0] instr_pc,
  output logic                 instr_err,
  cpu_if_prefetch_if.master    bus
);

  localparam int unsigned ByteW = DataWidth / 8;
  localparam int unsigned Lsb   = $clog2(ByteW);
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam int unsigned PtrW  = $clog2(Depth);

  localparam logic [AddrWidth-1:0] PcStep    = AddrWidth'(ByteW);
  localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'((64'd1 << Lsb) - 64'd1);
  localparam logic [CntW:0]        DepthCnt  = (CntW + 1)'(Depth);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] fetch_pc_q, fetch_pc_d;
  logic [AddrWidth-1:0] resp_pc_q, resp_pc_d;
  logic [CntW-1:0]      outstanding_q, outstanding_d;
  logic [CntW-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;

  logic [DataWidth-1:0] data_q [Depth];
  logic [AddrWidth-1:0] pc_q   [Depth];
  logic [Depth-1:0]     err_q;

  logic credit_s;
  logic stb_s;
  logic accept_s;
  logic resp_s;
  logic push_s;
  logic pop_s;

  // Credits cover both words in flight and words already queued, so a push never overflows.
  assign credit_s = ({1'b0, outstanding_q} + {1'b0, fifo_cnt_q}) < DepthCnt;
  assign stb_s    = (state_q == ST_FETCH) && credit_s && !redirect_valid && reset_n;
  assign accept_s = stb_s && !bus.bus_stall;
  assign resp_s   = bus.bus_ack || bus.bus_err;
  assign pop_s    = instr_valid && instr_ready && !redirect_valid;

  assign outstanding_d = outstanding_q + CntW'(accept_s) - CntW'(resp_s);

  // Fetch state machine and PC bookkeeping.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    push_s     = (state_q == ST_FETCH) && resp_s && !redirect_valid;

    if (accept_s) begin
      fetch_pc_d = fetch_pc_q + PcStep;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end

    if (push_s) begin
      resp_pc_d = resp_pc_q + PcStep;
    end else begin
      resp_pc_d = resp_pc_q;
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & AlignMask;
      resp_pc_d  = redirect_pc & AlignMask;
      if (outstanding_d == {CntW{1'b0}}) begin
        state_d = ST_FETCH;
      end else begin
        state_d = ST_DRAIN;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (bus.bus_err) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (outstanding_d == {CntW{1'b0}}) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_HALT:  state_d = ST_HALT;
        default:  state_d = ST_FETCH;
      endcase
    end
  end

  // FIFO pointer and occupancy update; a redirect empties the queue outright.
  always_comb begin
    if (redirect_valid) begin
      rd_ptr_d   = {PtrW{1'b0}};
      wr_ptr_d   = {PtrW{1'b0}};
      fifo_cnt_d = {CntW{1'b0}};
    end else begin
      rd_ptr_d   = rd_ptr_q + PtrW'(pop_s);
      wr_ptr_d   = wr_ptr_q + PtrW'(push_s);
      fifo_cnt_d = fifo_cnt_q + CntW'(push_s) - CntW'(pop_s);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_FETCH;
      fetch_pc_q    <= ResetPc;
      resp_pc_q     <= ResetPc;
      outstanding_q <= {CntW{1'b0}};
      fifo_cnt_q    <= {CntW{1'b0}};
      rd_ptr_q      <= {PtrW{1'b0}};
      wr_ptr_q      <= {PtrW{1'b0}};
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      fifo_cnt_q    <= fifo_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // FIFO storage: word, its PC and the bus error flag travel together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        data_q[i] <= {DataWidth{1'b0}};
        pc_q[i]   <= {AddrWidth{1'b0}};
      end
      err_q <= {Depth{1'b0}};
    end else if (push_s) begin
      data_q[wr_ptr_q] <= bus.bus_data_s;
      pc_q[wr_ptr_q]   <= resp_pc_q;
      err_q[wr_ptr_q]  <= bus.bus_err;
    end else begin
      err_q <= err_q;
    end
  end

  assign instr_valid = (fifo_cnt_q != {CntW{1'b0}});
  assign instr       = data_q[rd_ptr_q];
  assign instr_pc    = pc_q[rd_ptr_q];
  assign instr_err   = err_q[rd_ptr_q];

  assign bus.bus_addr   = fetch_pc_q;
  assign bus.bus_stb    = stb_s;
  assign bus.bus_cyc    = stb_s || (outstanding_q != {CntW{1'b0}});
  assign bus.bus_we     = 1'b0;
  assign bus.bus_sel    = {ByteW{1'b1}};
  assign bus.bus_data_m = {DataWidth{1'b0}};

endmodule
